alu_seq: RTL and testbench
==========================

# alu_seq

Registered, handshaked ALU: the parametrised successor of the combinational datapath ALU. It adds a Z/C/N/V flags output, carry-in for ADC, and an iterative one-bit-per-cycle shifter for multi-bit shifts. It sits between the control unit and the register file/flags register, and uses the same `opcode_t` encoding. Single-cycle ops sustain one result per clock; shifts stall the input side while they iterate.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE `` (8): operand/result width, ≥ 2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  the block accepts a request this cycle.
- `opcode`  in  `opcode_t`  operation.
- `a`, `b`  in  WORD_SIZE  operands; `b` is the shift count for SHL/SHR.
- `carry_in`  in  1  C flag from the flags register; used by ADC only.
- `out_valid`  out  1  `result`/`flags` are valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WORD_SIZE  registered result.
- `flags`  out  4  registered flags: [0]=Z, [1]=C, [2]=N, [3]=V.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Accept condition: `in_valid && in_ready`. Opcode, `a`, `b` and `carry_in` are captured at accept; input changes afterwards have no effect.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). This is combinational from state and `out_ready`.
- On accept of a non-shift op: compute the result, register `result`/`flags`, and go to DONE.
- On accept of SHL/SHR: load the accumulator with `a` and the counter with min(`b`, WORD_SIZE).
  - Count 0: go to DONE with `result`=`a` and C=0.
  - Otherwise go to SHIFT.
- SHIFT: each cycle shift the accumulator one bit (logical, zero-fill), set C = the bit shifted out, and decrement the counter. After the shift that brings the counter to 0, go to DONE.
- DONE: `out_valid`=1; `result`/`flags` are held stable until `out_ready`.
  - `out_ready` with no new accept: go to IDLE.
  - `out_ready` with a same-cycle accept: go to DONE or SHIFT per the new op.
- Arithmetic, with all sums at WORD_SIZE+1 bits:
  - ADD: a+b, C = carry out.
  - ADC: a+b+carry_in, C = carry out.
  - SUB: a−b, C = borrow (a<b unsigned).
  - CMP: identical to SUB for both result and flags.
  - INC: a+1, C = carry out.
  - DEC: a−1, C = borrow (a==0).
- V = two's-complement overflow for ADD/ADC/SUB/CMP/INC/DEC. V=0 for AND/OR/XOR/SHL/SHR.
- AND/OR/XOR: C=0.
- All ops: Z = (result==0), N = result[WORD_SIZE−1].
- Undefined opcode: result 0, flags Z=1, C=N=V=0, single-cycle path.

## Timing
- Reset state (asynchronous, while `rst_n`=0): IDLE, `out_valid`=0, `result`=0, `flags`=0, accumulator and counter cleared. `in_ready` reads 1, but nothing is accepted while `rst_n`=0.
- Reset mid-operation: an in-flight shift or an unconsumed result is discarded. The first accept is possible on the first rising edge with `rst_n`=1.
- Single-cycle op accepted at edge N: `out_valid`=1 after edge N+1.
- Shift with count k≥1 accepted at edge N: `out_valid`=1 after edge N+k+1. With k=0: after edge N+1.
- Throughput: with `out_ready` held at 1, back-to-back single-cycle ops produce one result per cycle. Any SHIFT state forces `in_ready`=0.
- `out_valid` drops the cycle after a handshake unless a new op completes in that same cycle.

## Test plan
- ADD a=0xFF b=0x01 → `result` 0x00, Z=1 C=1 N=0 V=0, `out_valid` one cycle after accept.
- SUB a=0x80 b=0x01 → 0x7F, V=1 C=0. ADC a=0x7F b=0x00 carry_in=1 → 0x80, N=1 V=1 C=0. DEC a=0x00 → 0xFF, C=1 N=1.
- SHL a=0x81 b=3 → 0x08, C=0, `out_valid` 4 cycles after accept, `in_ready`=0 during SHIFT. SHR a=0x81 b=1 → 0x40, C=1. SHR b=0 → 0x81, C=0, 1-cycle latency. SHR a=0x81 b=20 → 0x00, Z=1, C=1, 9-cycle latency.
- Backpressure: `out_ready`=0 for 5 cycles → `result`/`flags` stable, `in_ready`=0. Then 3 back-to-back INCs with `out_ready`=1 → 3 consecutive `out_valid` cycles, no bubble.
- `rst_n` pulsed low mid-SHL (b=7) → `out_valid` 0 immediately, state IDLE. The next ADD completes normally.
- CMP a=0x05 b=0x05 → `result` 0x00, Z=1. Undefined opcode → 0x00, flags 4'b0001.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered, handshaked ALU with Z/C/N/V flags, ADC carry-in and
//            an iterative one-bit-per-cycle shifter for SHL/SHR.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_ADC = 4'h1,
    OP_SUB = 4'h2,
    OP_CMP = 4'h3,
    OP_INC = 4'h4,
    OP_DEC = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_SHL = 4'h9,
    OP_SHR = 4'hA
  } opcode_t;
endpackage

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  opcode_t              opcode,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic [3:0]           flags
);

  localparam int unsigned          CW      = $clog2(WORD_SIZE + 1);
  localparam int unsigned          MSB     = WORD_SIZE - 1;
  localparam logic [CW-1:0]        CNT_MAX = CW'(WORD_SIZE);
  localparam logic [WORD_SIZE-1:0] W_LIM   = WORD_SIZE'(WORD_SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 dir_q, dir_d;   // 1 = shift right

  logic                 accept;
  logic                 is_shift;
  logic [CW-1:0]        cnt_load;
  logic [WORD_SIZE-1:0] opnd;
  logic                 arith, sub_op, cin;
  logic [WORD_SIZE:0]   sum;
  logic [WORD_SIZE-1:0] alu_res;
  logic                 alu_c, alu_v;
  logic [WORD_SIZE-1:0] shifted;
  logic                 shift_out;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign accept    = in_valid && in_ready;
  assign is_shift  = (opcode == OP_SHL) || (opcode == OP_SHR);
  assign cnt_load  = (b >= W_LIM) ? CNT_MAX : b[CW-1:0];

  always_comb begin
    opnd    = b;
    arith   = 1'b0;
    sub_op  = 1'b0;
    cin     = 1'b0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD:         arith = 1'b1;
      OP_ADC:         begin arith = 1'b1; cin = carry_in; end
      OP_SUB, OP_CMP: begin arith = 1'b1; sub_op = 1'b1; end
      OP_INC:         begin arith = 1'b1; opnd = WORD_SIZE'(1); end
      OP_DEC:         begin arith = 1'b1; sub_op = 1'b1; opnd = WORD_SIZE'(1); end
      OP_AND:         alu_res = a & b;
      OP_OR:          alu_res = a | b;
      OP_XOR:         alu_res = a ^ b;
      default:        alu_res = '0;
    endcase
    // Top bit of the widened subtraction is the unsigned borrow.
    sum = sub_op ? ({1'b0, a} - {1'b0, opnd})
                 : ({1'b0, a} + {1'b0, opnd} + {{WORD_SIZE{1'b0}}, cin});
    if (arith) begin
      alu_res = sum[WORD_SIZE-1:0];
      alu_c   = sum[WORD_SIZE];
      alu_v   = sub_op ? ((a[MSB] != opnd[MSB]) && (alu_res[MSB] != a[MSB]))
                       : ((a[MSB] == opnd[MSB]) && (alu_res[MSB] != a[MSB]));
    end
  end

  assign shifted   = dir_q ? (acc_q >> 1) : (acc_q << 1);
  assign shift_out = dir_q ? acc_q[0] : acc_q[MSB];

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    if (accept) begin
      if (is_shift) begin
        acc_d = a;
        cnt_d = cnt_load;
        dir_d = (opcode == OP_SHR);
        if (cnt_load == '0) begin
          state_d  = S_DONE;
          result_d = a;
          flags_d  = {1'b0, a[MSB], 1'b0, (a == '0)};
        end else begin
          state_d = S_SHIFT;
        end
      end else begin
        state_d  = S_DONE;
        result_d = alu_res;
        flags_d  = {alu_v, alu_res[MSB], alu_c, (alu_res == '0)};
      end
    end else begin
      case (state_q)
        S_SHIFT: begin
          acc_d = shifted;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d  = S_DONE;
            result_d = shifted;
            flags_d  = {1'b0, shifted[MSB], shift_out, (shifted == '0)};
          end
        end
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq: vector table, random ops
//            against an arithmetic reference model, handshake/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  opcode_t      opcode;
  logic [W-1:0] a, b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op; int av; int bv; int cin; int res; int fl; int lat;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Flags computed from the arithmetic meaning of each op on plain integers.
  function automatic void model(input int op, input int av, input int bv, input int cin,
                                output int res, output int fl, output int lat);
    int m, sa, sb, raw, ideal, n;
    bit c, v, arith;
    m = 1 << W;
    sa = (av >= m/2) ? av - m : av;
    sb = (bv >= m/2) ? bv - m : bv;
    raw = 0; ideal = 0; c = 0; arith = 1; lat = 1;
    case (op)
      0: begin raw = av + bv;       c = (raw >= m);   ideal = sa + sb; end
      1: begin raw = av + bv + cin; c = (raw >= m);   ideal = sa + sb + cin; end
      2, 3: begin raw = av - bv;    c = (av < bv);    ideal = sa - sb; end
      4: begin raw = av + 1;        c = (av == m-1);  ideal = sa + 1; end
      5: begin raw = av - 1;        c = (av == 0);    ideal = sa - 1; end
      6: begin raw = av & bv; arith = 0; end
      7: begin raw = av | bv; arith = 0; end
      8: begin raw = av ^ bv; arith = 0; end
      9, 10: begin
        arith = 0;
        n = (bv > W) ? W : bv;
        lat = (n == 0) ? 1 : n + 1;
        if (op == 9) begin
          raw = (n == W) ? 0 : (av * (1 << n)) % m;
          c = (n > 0) ? ((av >> (W - n)) & 1) : 0;
        end else begin
          raw = (n == W) ? 0 : av / (1 << n);
          c = (n > 0) ? ((av >> (n - 1)) & 1) : 0;
        end
      end
      default: begin raw = 0; arith = 0; end
    endcase
    res = ((raw % m) + m) % m;
    v = arith && (ideal > m/2 - 1 || ideal < -(m/2));
    fl = (int'(v) << 3) | (int'(res >= m/2) << 2) | (int'(c) << 1) | int'(res == 0);
  endfunction

  task automatic drive(input int op, input int av, input int bv, input int cin);
    logic [3:0] op4;
    int tmp;
    tmp = op;
    op4 = tmp[3:0];
    opcode   = opcode_t'(op4);
    a        = W'(av);
    b        = W'(bv);
    carry_in = cin[0];
  endtask

  // Accepts one op and waits (bounded) for out_valid; result is left unconsumed.
  task automatic do_op(input int op, input int av, input int bv, input int cin,
                       output int res, output int fl, output int lat, output bit rdy_seen);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    drive(op, av, bv, cin);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    drive(0, 0, 0, 0);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 64) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    res = int'(result);
    fl  = int'(flags);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[15];
    int res, fl, lat, eres, efl, elat;
    bit rdy;
    int op, av, bv, cin;

    vecs[0]  = '{0,  'hFF, 'h01, 0, 'h00, 4'b0011, 1};
    vecs[1]  = '{2,  'h80, 'h01, 0, 'h7F, 4'b1000, 1};
    vecs[2]  = '{1,  'h7F, 'h00, 1, 'h80, 4'b1100, 1};
    vecs[3]  = '{5,  'h00, 'h00, 0, 'hFF, 4'b0110, 1};
    vecs[4]  = '{9,  'h81, 3,    0, 'h08, 4'b0000, 4};
    vecs[5]  = '{10, 'h81, 1,    0, 'h40, 4'b0010, 2};
    vecs[6]  = '{10, 'h81, 0,    0, 'h81, 4'b0100, 1};
    vecs[7]  = '{10, 'h81, 20,   0, 'h00, 4'b0011, 9};
    vecs[8]  = '{3,  'h05, 'h05, 0, 'h00, 4'b0001, 1};
    vecs[9]  = '{15, 'h5A, 'hA5, 1, 'h00, 4'b0001, 1};
    vecs[10] = '{6,  'hF0, 'h3C, 1, 'h30, 4'b0000, 1};
    vecs[11] = '{8,  'hAA, 'hAA, 0, 'h00, 4'b0001, 1};
    vecs[12] = '{4,  'h7F, 'h00, 0, 'h80, 4'b1100, 1};
    vecs[13] = '{7,  'h00, 'h80, 0, 'h80, 4'b0100, 1};
    vecs[14] = '{4,  'hFF, 'h00, 1, 'h00, 4'b0011, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_result", int'(result), 0);
    check("reset_flags", int'(flags), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].cin, res, fl, lat, rdy);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_flags", i), fl, vecs[i].fl);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1) check($sformatf("vec%0d_in_ready_shift", i), int'(rdy), 0);
      consume();
    end

    for (int i = 0; i < 150; i++) begin
      op  = $urandom_range(0, 15);
      av  = $urandom_range(0, 255);
      bv  = (op == 9 || op == 10) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      cin = $urandom_range(0, 1);
      model(op, av, bv, cin, eres, efl, elat);
      do_op(op, av, bv, cin, res, fl, lat, rdy);
      check($sformatf("rand%0d_op%0d_result", i, op), res, eres);
      check($sformatf("rand%0d_op%0d_flags", i, op), fl, efl);
      check($sformatf("rand%0d_op%0d_latency", i, op), lat, elat);
      consume();
    end

    // Backpressure: result held while out_ready is low.
    model(0, 'h12, 'h34, 0, eres, efl, elat);
    do_op(0, 'h12, 'h34, 0, res, fl, lat, rdy);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_result", int'(result), eres);
      check("bp_flags", int'(flags), efl);
      check("bp_in_ready", int'(in_ready), 0);
    end

    // Three back-to-back INCs, each accepted on the edge consuming the previous result.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(4, 10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      model(4, 10 + 10*i, 0, 0, eres, efl, elat);
      check("b2b_out_valid", int'(out_valid), 1);
      check("b2b_result", int'(result), eres);
      check("b2b_flags", int'(flags), efl);
      drive(4, 20 + 10*i, 0, 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_drain_out_valid", int'(out_valid), 0);
    out_ready = 1'b0;

    // Reset in the middle of a 7-step shift.
    drive(9, 'hFF, 7, 0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("shift_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    check("rst_mid_result", int'(result), 0);
    repeat (8) @(negedge clk);
    check("rst_hold_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    model(0, 3, 4, 0, eres, efl, elat);
    do_op(0, 3, 4, 0, res, fl, lat, rdy);
    check("post_rst_result", res, eres);
    check("post_rst_latency", lat, 1);

    // Reset discards an unconsumed result.
    rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", int'(out_valid), 0);
    check("rst_done_flags", int'(flags), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done_idle", int'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
